// File: rtl/computer_system_button_pio.sv
// rtl/computer_system_button_pio.sv - Avalon-MM input PIO with edge capture and maskable IRQ (optional debounce: COMPUTER_SYSTEM_BUTTON_DEBOUNCE_EN)
module computer_system_button_pio #(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [31:0]       readdata,
    output logic              irq
);

    // Priming window: edge detection stays off until the synchroniser has filled
    localparam int PRIME_MAX = SYNC_STAGES + 1;
    localparam int PW        = $clog2(PRIME_MAX + 1);
    localparam logic [PW-1:0] PRIME_LAST = PW'(PRIME_MAX);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] cin;
    logic [WIDTH-1:0] cin_d;
    logic [WIDTH-1:0] edge_raw;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] capture;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] clear_bits;
    logic [PW-1:0]    prime_cnt;
    logic             primed;
    logic             wr_en;
    logic [31:0]      rd_mux;
    logic             unused_bits;

    assign unused_bits = ^writedata;
    assign wr_en       = chipselect && !write_n;
    assign primed      = (prime_cnt == PRIME_LAST);
    assign sync_out    = sync_q[SYNC_STAGES-1];

    // Per-bit synchroniser chain for the asynchronous inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

`ifdef COMPUTER_SYSTEM_BUTTON_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] db_cnt [WIDTH];

    // Debounce: a bit must differ from cin for DEBOUNCE_CYCLES consecutive cycles to be accepted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cin <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                db_cnt[i] <= '0;
            end
        end else if (!primed) begin
            cin <= sync_out;
            for (int i = 0; i < WIDTH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_out[i] == cin[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    cin[i]    <= sync_out[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign cin = sync_out;
`endif

    // Priming counter, saturating once the window has elapsed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prime_cnt <= '0;
        end else if (!primed) begin
            prime_cnt <= prime_cnt + 1'b1;
        end
    end

    // Delayed copy of cin; while priming it follows the value cin is loading so no edge appears
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cin_d <= '0;
        end else if (!primed) begin
            cin_d <= sync_out;
        end else begin
            cin_d <= cin;
        end
    end

    // Edge selection by EDGE_TYPE, gated off during priming
    always_comb begin
        edge_raw = cin ^ cin_d;
        if (EDGE_TYPE == 0) begin
            edge_raw = cin & ~cin_d;
        end else if (EDGE_TYPE == 1) begin
            edge_raw = ~cin & cin_d;
        end
        edge_det = primed ? edge_raw : '0;
    end

    // Write-1-to-clear mask for the edge-capture register
    always_comb begin
        clear_bits = '0;
        if (wr_en && address == 2'd3) begin
            clear_bits = writedata[WIDTH-1:0];
        end
    end

    // Edge capture: a new edge wins over a simultaneous clear of the same bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            capture <= '0;
        end else begin
            capture <= (capture & ~clear_bits) | edge_det;
        end
    end

    // Interrupt mask register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask <= '0;
        end else if (wr_en && address == 2'd2) begin
            mask <= writedata[WIDTH-1:0];
        end
    end

    // Read mux, zero-extended above WIDTH
    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[WIDTH-1:0] = cin;
            2'd2:    rd_mux[WIDTH-1:0] = mask;
            2'd3:    rd_mux[WIDTH-1:0] = capture;
            default: rd_mux = '0;
        endcase
    end

    // Registered read data, one cycle of latency, independent of chipselect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

    assign irq = |(capture & mask);

endmodule

// File: tb/tb_computer_system_button_pio.sv
// tb/tb_computer_system_button_pio.sv - directed self-checking bench for computer_system_button_pio
module tb_computer_system_button_pio;

    localparam int WIDTH = 4;
    localparam int SYNC  = 2;
    localparam int DEB   = 8;
`ifdef COMPUTER_SYSTEM_BUTTON_DEBOUNCE_EN
    localparam int LAT = SYNC + DEB + 1;
`else
    localparam int LAT = SYNC + 1;
`endif

    logic             clk;
    logic             reset_n;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [WIDTH-1:0] in_port;
    logic [31:0]      readdata;
    logic             irq;

    int n_checks;
    int n_pass;
    logic [31:0] rd;

    computer_system_button_pio #(
        .WIDTH(WIDTH),
        .EDGE_TYPE(1),
        .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .in_port(in_port),
        .readdata(readdata),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        tick();
        d = readdata;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;

        // reset state with buttons idle high
        ticks(3);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        ticks(10 + DEB);
        reg_read(2'd3, rd);
        check("prime_capture", rd, 32'h0);
        reg_read(2'd0, rd);
        check("prime_data", rd, 32'hF);
        check("prime_irq", {31'b0, irq}, 32'h0);

        // falling edge on bit0 with mask=1, latency check
        reg_write(2'd2, 32'h1);
        in_port = 4'hE;
        ticks(LAT - 1);
        check("lat_irq_early", {31'b0, irq}, 32'h0);
        tick();
        check("lat_irq_on_time", {31'b0, irq}, 32'h1);
        reg_read(2'd3, rd);
        check("fall_capture", rd, 32'h1);

        // W1C coinciding with a new falling edge: set wins
        in_port = 4'hF;
        ticks(LAT + 2);
        in_port = 4'hE;
        ticks(LAT - 1);
        reg_write(2'd3, 32'h1);
        reg_read(2'd3, rd);
        check("set_wins_capture", rd, 32'h1);
        check("set_wins_irq", {31'b0, irq}, 32'h1);
        reg_write(2'd3, 32'h1);
        check("w1c_irq", {31'b0, irq}, 32'h0);
        reg_read(2'd3, rd);
        check("w1c_capture", rd, 32'h0);

        // masked capture, then enabling the mask raises irq next cycle
        reg_write(2'd2, 32'h0);
        in_port = 4'hA;
        ticks(LAT + 2);
        check("masked_irq", {31'b0, irq}, 32'h0);
        reg_read(2'd3, rd);
        check("masked_capture", rd, 32'h4);
        reg_read(2'd0, rd);
        check("data_A", rd, 32'hA);
        reg_write(2'd2, 32'h4);
        check("unmask_irq", {31'b0, irq}, 32'h1);

        // reserved register reads zero and ignores writes
        reg_write(2'd1, 32'hFFFF_FFFF);
        reg_read(2'd1, rd);
        check("reserved_zero", rd, 32'h0);

        // build capture=0x5 with mask=0xF, then async reset mid-cycle
        in_port = 4'hB;
        ticks(LAT + 2);
        in_port = 4'hA;
        ticks(LAT + 2);
        reg_write(2'd2, 32'hF);
        reg_read(2'd2, rd);
        check("mask_F", rd, 32'hF);
        reg_read(2'd3, rd);
        check("capture_5", rd, 32'h5);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_irq", {31'b0, irq}, 32'h0);
        check("async_readdata", readdata, 32'h0);
        ticks(2);
        reset_n = 1'b1;
        ticks(10 + DEB);
        reg_read(2'd2, rd);
        check("post_reset_mask", rd, 32'h0);
        reg_read(2'd3, rd);
        check("post_reset_capture", rd, 32'h0);
        check("post_reset_irq", {31'b0, irq}, 32'h0);

`ifdef COMPUTER_SYSTEM_BUTTON_DEBOUNCE_EN
        // bounce on bit1: low 5, high 1, then stable low
        reg_write(2'd2, 32'h2);
        in_port = 4'h8;
        ticks(5);
        in_port = 4'hA;
        tick();
        in_port = 4'h8;
        ticks(LAT - 1);
        check("deb_irq_early", {31'b0, irq}, 32'h0);
        tick();
        check("deb_irq", {31'b0, irq}, 32'h1);
        reg_read(2'd3, rd);
        check("deb_capture", rd, 32'h2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
